// File: rtl/game_pkg.sv
// Shared game definitions for the level sequencer and the enemy-configuration
// logic: the game state encoding seen by the display, the level count, and the
// one-hot level codes driven on Level_Active.
package game_pkg;

    localparam int NUM_LEVELS = 3;

    typedef enum logic [2:0] {
        TITLE      = 3'd0,
        PLAY       = 3'd1,
        DEATH      = 3'd2,
        TRANSITION = 3'd3,
        WIN        = 3'd4
    } game_state_t;

    localparam logic [NUM_LEVELS-1:0] LVL1     = 3'b001;
    localparam logic [NUM_LEVELS-1:0] LVL2     = 3'b010;
    localparam logic [NUM_LEVELS-1:0] LVL3     = 3'b100;
    localparam logic [NUM_LEVELS-1:0] LVL_NONE = 3'b000;

    // Countdowns run from frames-1 down to 0, so a duration of N frames
    // is loaded as N-1 (1..256 frames fits the 8-bit counter).
    function automatic logic [7:0] countdown_load(input int frames);
        return 8'(frames - 1);
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Handshake bundle between the level sequencer and the rest of the game.
//   start, collision, goal_reached : from keyboard / collision / goal detection
//   Level_Active   : one-hot current level to enemy generation (0 = enemies held in reset)
//   player_respawn : one-frame pulse to move the player to the level spawn
//   freeze         : player movement must be ignored
//   deaths         : saturating death count since the last game start
//   game_state     : encoded state for the display
//   timer          : frames remaining in the death / level-complete countdown
// The sequencer uses the slave modport; whatever drives the inputs uses master.
interface level_sequencer_if #(
    parameter int NUM_LEVELS = 3,
    parameter int DEATH_W    = 10
);
    logic                  start;
    logic                  collision;
    logic                  goal_reached;
    logic [NUM_LEVELS-1:0] Level_Active;
    logic                  player_respawn;
    logic                  freeze;
    logic [DEATH_W-1:0]    deaths;
    logic [2:0]            game_state;
    logic [7:0]            timer;

    modport master (
        output start, collision, goal_reached,
        input  Level_Active, player_respawn, freeze, deaths, game_state, timer
    );

    modport slave (
        input  start, collision, goal_reached,
        output Level_Active, player_respawn, freeze, deaths, game_state, timer
    );
endinterface

// File: rtl/frame_countdown.sv
// 8-bit per-frame countdown shared by the death freeze and the level-complete
// screen.
//   clk, rst   : frame clock, async active-high reset
//   load       : load load_value this frame (wins over everything else)
//   enable     : countdown active; when low the counter is forced to 0
//   load_value : starting value (frames - 1)
//   value      : current count
//   zero       : value is 0 (last frame of the countdown)
module frame_countdown (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic       zero
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Count stops at 0 rather than wrapping; the owner leaves the counting
    // state on that same frame.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (!enable) begin
            value_d = 8'd0;
        end else if (value_q != 8'd0) begin
            value_d = value_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == 8'd0);

endmodule

// File: rtl/level_sequencer.sv
// Top-level game controller, one state update per video frame.
// Sequences title -> level 1..NUM_LEVELS -> win screen, freezes and respawns
// the player after a collision, and shows a timed level-complete screen
// between levels.
//   frame_clk : one rising edge per frame
//   Reset     : async active-high reset back to the title screen
//   bus       : game handshake bundle (see level_sequencer_if)
// Every output comes straight from a flop.
module level_sequencer #(
    parameter int NUM_LEVELS        = game_pkg::NUM_LEVELS,
    parameter int DEATH_FRAMES      = 60,
    parameter int TRANSITION_FRAMES = 90,
    parameter int DEATH_W           = 10
) (
    input  logic                frame_clk,
    input  logic                Reset,
    level_sequencer_if.slave    bus
);
    import game_pkg::*;

    localparam int                LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
    localparam logic [7:0]        DEATH_LOAD = countdown_load(DEATH_FRAMES);
    localparam logic [7:0]        TRANS_LOAD = countdown_load(TRANSITION_FRAMES);

    game_state_t           state_q, state_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [DEATH_W-1:0]    deaths_q, deaths_d;
    logic                  respawn_q, respawn_d;
    logic                  freeze_q, freeze_d;
    logic [NUM_LEVELS-1:0] level_active_q, level_active_d;
    logic                  start_q;
    logic                  start_edge;
    logic                  timer_load;
    logic                  timer_enable;
    logic [7:0]            timer_load_value;
    logic [7:0]            timer_value;
    logic                  timer_zero;

    // Holding the start key must not retrigger, so only a fresh press counts.
    assign start_edge   = bus.start & ~start_q;
    assign timer_enable = (state_q == DEATH) || (state_q == TRANSITION);

    frame_countdown u_countdown (
        .clk        (frame_clk),
        .rst        (Reset),
        .load       (timer_load),
        .enable     (timer_enable),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // Next-state logic. Collision is checked before goal so a death in the
    // end zone never advances the level. Level_Active and freeze are derived
    // from the next state so they land in the same frame as the state change.
    always_comb begin
        state_d          = state_q;
        level_d          = level_q;
        deaths_d         = deaths_q;
        respawn_d        = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = 8'd0;
        level_active_d   = '0;
        freeze_d         = 1'b1;

        case (state_q)
            TITLE: begin
                if (start_edge) begin
                    state_d   = PLAY;
                    level_d   = '0;
                    deaths_d  = '0;
                    respawn_d = 1'b1;
                end
            end
            PLAY: begin
                if (bus.collision) begin
                    state_d          = DEATH;
                    timer_load       = 1'b1;
                    timer_load_value = DEATH_LOAD;
                    if (deaths_q != {DEATH_W{1'b1}}) begin
                        deaths_d = deaths_q + 1'b1;
                    end
                end else if (bus.goal_reached) begin
                    if (level_q >= LAST_LEVEL) begin
                        state_d = WIN;
                    end else begin
                        state_d          = TRANSITION;
                        timer_load       = 1'b1;
                        timer_load_value = TRANS_LOAD;
                    end
                end
            end
            DEATH: begin
                if (timer_zero) begin
                    state_d   = PLAY;
                    respawn_d = 1'b1;
                end
            end
            TRANSITION: begin
                if (timer_zero) begin
                    state_d   = PLAY;
                    level_d   = (level_q >= LAST_LEVEL) ? LAST_LEVEL : level_q + 1'b1;
                    respawn_d = 1'b1;
                end
            end
            WIN: begin
                if (start_edge) begin
                    state_d = TITLE;
                end
            end
            default: begin
                state_d = TITLE;
                level_d = '0;
            end
        endcase

        // Enemies run in PLAY and DEATH only; elsewhere they sit in reset.
        if (((state_d == PLAY) || (state_d == DEATH)) && (level_d <= LAST_LEVEL)) begin
            level_active_d[level_d] = 1'b1;
        end
        freeze_d = (state_d != PLAY);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= TITLE;
            level_q        <= '0;
            deaths_q       <= '0;
            respawn_q      <= 1'b0;
            freeze_q       <= 1'b1;
            level_active_q <= '0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            deaths_q       <= deaths_d;
            respawn_q      <= respawn_d;
            freeze_q       <= freeze_d;
            level_active_q <= level_active_d;
            start_q        <= bus.start;
        end
    end

    assign bus.Level_Active   = level_active_q;
    assign bus.player_respawn = respawn_q;
    assign bus.freeze         = freeze_q;
    assign bus.deaths         = deaths_q;
    assign bus.game_state     = state_q;
    assign bus.timer          = timer_value;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer. DUT A uses the default 60/90 frame
// timings and walks the full game; DUT B uses 1-frame timings to cover the
// single-frozen-frame case and drives the death counter into saturation.
module tb_level_sequencer;
    import game_pkg::*;

    logic frame_clk = 1'b0;
    logic resetA    = 1'b1;
    logic resetB    = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;
    int   pulses;
    int   frozen;

    level_sequencer_if #(.NUM_LEVELS(3), .DEATH_W(10)) busA ();
    level_sequencer_if #(.NUM_LEVELS(3), .DEATH_W(10)) busB ();

    level_sequencer #(
        .NUM_LEVELS(3), .DEATH_FRAMES(60), .TRANSITION_FRAMES(90), .DEATH_W(10)
    ) dutA (
        .frame_clk (frame_clk),
        .Reset     (resetA),
        .bus       (busA)
    );

    level_sequencer #(
        .NUM_LEVELS(3), .DEATH_FRAMES(1), .TRANSITION_FRAMES(1), .DEATH_W(10)
    ) dutB (
        .frame_clk (frame_clk),
        .Reset     (resetB),
        .bus       (busB)
    );

    // One frame every 10 time units; checks and input changes happen on the
    // falling edge, well away from the rising edge the DUT samples on.
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives the same inputs to both DUTs and advances one frame.
    task automatic applyStimulus(input logic s, input logic c, input logic g);
        busA.start = s; busA.collision = c; busA.goal_reached = g;
        busB.start = s; busB.collision = c; busB.goal_reached = g;
        @(negedge frame_clk);
    endtask

    // Counts frames with DUT A frozen, including the current one.
    task automatic waitUnfrozen(output int frames);
        frames = 1;
        busA.start = 1'b0; busA.collision = 1'b0; busA.goal_reached = 1'b0;
        busB.start = 1'b0; busB.collision = 1'b0; busB.goal_reached = 1'b0;
        for (int i = 0; i < 300 && busA.freeze; i++) begin
            @(negedge frame_clk);
            if (busA.freeze) frames++;
        end
    endtask

    initial begin
        busA.start = 1'b0; busA.collision = 1'b0; busA.goal_reached = 1'b0;
        busB.start = 1'b0; busB.collision = 1'b0; busB.goal_reached = 1'b0;
        @(negedge frame_clk);

        checkOutput("rst_state",   32'(busA.game_state), 32'(TITLE));
        checkOutput("rst_level",   32'(busA.Level_Active), 32'(LVL_NONE));
        checkOutput("rst_deaths",  32'(busA.deaths), 32'd0);
        checkOutput("rst_freeze",  32'(busA.freeze), 32'd1);
        checkOutput("rst_timer",   32'(busA.timer), 32'd0);
        checkOutput("rst_respawn", 32'(busA.player_respawn), 32'd0);
        resetA = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("title_idle", 32'(busA.game_state), 32'(TITLE));

        // Start held for 10 frames: exactly one entry to PLAY, one respawn.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            pulses += int'(busA.player_respawn);
            if (i == 0) begin
                checkOutput("start_state",  32'(busA.game_state), 32'(PLAY));
                checkOutput("start_level",  32'(busA.Level_Active), 32'(LVL1));
                checkOutput("start_freeze", 32'(busA.freeze), 32'd0);
            end
        end
        checkOutput("start_pulses", 32'(pulses), 32'd1);
        checkOutput("start_held",   32'(busA.game_state), 32'(PLAY));

        // Collision in level 1.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("death_state",  32'(busA.game_state), 32'(DEATH));
        checkOutput("death_count",  32'(busA.deaths), 32'd1);
        checkOutput("death_level",  32'(busA.Level_Active), 32'(LVL1));
        checkOutput("death_timer",  32'(busA.timer), 32'd59);
        waitUnfrozen(frozen);
        checkOutput("death_frames", 32'(frozen), 32'd60);
        checkOutput("death_exit",   32'(busA.game_state), 32'(PLAY));
        checkOutput("death_respawn",32'(busA.player_respawn), 32'd1);
        checkOutput("death_tmr0",   32'(busA.timer), 32'd0);
        checkOutput("death_lvlkeep",32'(busA.Level_Active), 32'(LVL1));

        // Level 1 -> 2.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("trans1_state", 32'(busA.game_state), 32'(TRANSITION));
        checkOutput("trans1_level", 32'(busA.Level_Active), 32'(LVL_NONE));
        checkOutput("trans1_timer", 32'(busA.timer), 32'd89);
        waitUnfrozen(frozen);
        checkOutput("trans1_frames", 32'(frozen), 32'd90);
        checkOutput("l2_level",     32'(busA.Level_Active), 32'(LVL2));
        checkOutput("l2_respawn",   32'(busA.player_respawn), 32'd1);
        checkOutput("l2_deaths",    32'(busA.deaths), 32'd1);

        // Level 2 -> 3.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("trans2_state", 32'(busA.game_state), 32'(TRANSITION));
        waitUnfrozen(frozen);
        checkOutput("trans2_frames", 32'(frozen), 32'd90);
        checkOutput("l3_level",     32'(busA.Level_Active), 32'(LVL3));

        // Level 3 goal -> WIN, then back to TITLE and a fresh game.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("win_state",  32'(busA.game_state), 32'(WIN));
        checkOutput("win_level",  32'(busA.Level_Active), 32'(LVL_NONE));
        checkOutput("win_deaths", 32'(busA.deaths), 32'd1);
        checkOutput("win_freeze", 32'(busA.freeze), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("win_title",  32'(busA.game_state), 32'(TITLE));
        checkOutput("title_deaths", 32'(busA.deaths), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_state",  32'(busA.game_state), 32'(PLAY));
        checkOutput("restart_deaths", 32'(busA.deaths), 32'd0);
        checkOutput("restart_level",  32'(busA.Level_Active), 32'(LVL1));

        // Collision and goal together: death wins, no level advance.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("both_state",  32'(busA.game_state), 32'(DEATH));
        checkOutput("both_deaths", 32'(busA.deaths), 32'd1);
        waitUnfrozen(frozen);
        checkOutput("both_level",  32'(busA.Level_Active), 32'(LVL1));
        checkOutput("both_play",   32'(busA.game_state), 32'(PLAY));

        // Async reset in the middle of a level-complete countdown.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("trans3_timer", 32'(busA.timer), 32'd89);
        for (int i = 0; i < 49; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midtrans_timer", 32'(busA.timer), 32'd40);
        #2 resetA = 1'b1;
        #1;
        checkOutput("arst_state",  32'(busA.game_state), 32'(TITLE));
        checkOutput("arst_timer",  32'(busA.timer), 32'd0);
        checkOutput("arst_level",  32'(busA.Level_Active), 32'(LVL_NONE));
        checkOutput("arst_deaths", 32'(busA.deaths), 32'd0);
        checkOutput("arst_freeze", 32'(busA.freeze), 32'd1);
        @(negedge frame_clk);
        resetA = 1'b0;

        // DUT B: 1-frame death and transition.
        resetB = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b_start", 32'(busB.game_state), 32'(PLAY));
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("b_death_state",  32'(busB.game_state), 32'(DEATH));
        checkOutput("b_death_timer",  32'(busB.timer), 32'd0);
        checkOutput("b_death_freeze", 32'(busB.freeze), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b_respawn_state", 32'(busB.game_state), 32'(PLAY));
        checkOutput("b_respawn_pulse", 32'(busB.player_respawn), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("b_trans_state", 32'(busB.game_state), 32'(TRANSITION));
        checkOutput("b_trans_level", 32'(busB.Level_Active), 32'(LVL_NONE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b_l2_level",   32'(busB.Level_Active), 32'(LVL2));
        checkOutput("b_l2_respawn", 32'(busB.player_respawn), 32'd1);

        // Continuous collisions drive the death counter to saturation.
        for (int i = 0; i < 3000 && busB.deaths != 10'd1023; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("b_sat_reach", 32'(busB.deaths), 32'd1023);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("b_sat_hold",  32'(busB.deaths), 32'd1023);
        checkOutput("b_sat_level", 32'(busB.Level_Active), 32'(LVL2));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Top-level game controller, clocked on frame_clk.
- Drives the one-hot Level_Active bus into the enemy-generation logic and sequences the game: title → level 1..NUM_LEVELS → win screen.
- Handles player death (freeze, respawn, death count) and timed inter-level transitions.
- Sits between the keyboard/collision/goal detection logic and the enemy/player/display blocks.

Parameters:
NUM_LEVELS, 3, number of playable levels; Level_Active width equals NUM_LEVELS (one-hot)
DEATH_FRAMES, 60, frames the game freezes after a collision before respawn
TRANSITION_FRAMES, 90, frames of the "level complete" screen between levels
DEATH_W, 10, width of the saturating death counter

Ports:
frame_clk  input  1  frame clock, one rising edge per video frame
Reset  input  1  asynchronous, active-high reset
start  input  1  start/continue key level, synchronous to frame_clk
collision  input  1  player overlaps an enabled enemy this frame
goal_reached  input  1  player inside the level's end zone this frame
Level_Active  output  NUM_LEVELS  one-hot current level; all-zero means no enemies, enemies held in reset
player_respawn  output  1  one-frame pulse: move the player to the current level's spawn point
freeze  output  1  high while player movement must be ignored
deaths  output  DEATH_W  total deaths since last game start, saturating
game_state  output  3  encoded state for the display: TITLE=0, PLAY=1, DEATH=2, TRANSITION=3, WIN=4
timer  output  8  frames remaining in the DEATH/TRANSITION countdown, 0 otherwise

Behaviour:
- Reset (async): state=TITLE, level index=0, Level_Active=0, deaths=0, timer=0, player_respawn=0, freeze=1, start_q=0.
- start edge: start_edge = start & ~start_q, with start_q registered every frame. Holding the key never retriggers.
- TITLE:
  - Level_Active=0, freeze=1.
  - On start_edge: go to PLAY, level=0, deaths=0, player_respawn=1 in the next frame.
- PLAY:
  - Level_Active = 1<<level, freeze=0.
  - collision: go to DEATH, timer=DEATH_FRAMES-1, deaths += 1, saturating at all-ones.
  - else goal_reached: if level==NUM_LEVELS-1, go to WIN; else go to TRANSITION with timer=TRANSITION_FRAMES-1.
  - collision and goal_reached in the same frame: collision wins, death counted, no level advance.
- DEATH:
  - Level_Active = 1<<level, so enemies keep moving; freeze=1.
  - timer decrements each frame.
  - On the frame timer==0: go to PLAY and pulse player_respawn for that frame. Collision/goal are ignored while in DEATH.
- TRANSITION:
  - Level_Active=0, so enemies reset to their start positions; freeze=1.
  - timer decrements each frame.
  - At timer==0: level += 1, go to PLAY, pulse player_respawn. The level update and the Level_Active change land in the same frame.
- WIN:
  - Level_Active=0, freeze=1, deaths held for display.
  - On start_edge: go to TITLE.
- Outputs and timing:
  - All outputs are registered; no combinational path from inputs to outputs.
  - Input-to-state-change latency is 1 frame.
  - player_respawn is high for exactly 1 frame per respawn.
  - timer is only ever loaded in DEATH/TRANSITION and forced to 0 in the other states.
- Invariants:
  - Level_Active is never multi-hot.
  - level never exceeds NUM_LEVELS-1; illegal state encodings recover to TITLE.
- Reset mid-operation (any state, any timer value) returns to TITLE immediately and asynchronously. Deaths clear.
- DEATH_FRAMES and TRANSITION_FRAMES must be 1..256. A value of 1 gives a single frozen frame.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic [2:0] game_state_t {TITLE, PLAY, DEATH, TRANSITION, WIN}
  - localparam NUM_LEVELS
  - level one-hot constants LVL1=3'b001, LVL2=3'b010, LVL3=3'b100, LVL_NONE=3'b000, shared with the enemy-configuration logic.
- One natural sub-module, frame_countdown: 8-bit load/decrement counter with load, value and zero flag. It is used for both the death and transition timers.

Test Plan:
- Reset → Level_Active=000, game_state=0, deaths=0, freeze=1. start held high 10 frames → exactly one transition to PLAY, Level_Active=001, player_respawn high 1 frame.
- In PLAY L1, assert collision 1 frame → game_state=2, deaths=1, Level_Active stays 001, freeze=1 for 60 frames. Then PLAY with player_respawn pulse, timer=0.
- In PLAY L1, assert goal_reached → game_state=3, Level_Active=000 for 90 frames. Then Level_Active=010 and PLAY with respawn pulse; repeat from L2 → Level_Active=100.
- In PLAY L3 with goal_reached → WIN, Level_Active=000, deaths retained. start edge → TITLE; next start edge → deaths cleared to 0.
- collision and goal_reached in the same frame in L1 → DEATH, deaths+1, level unchanged (Level_Active=001 after respawn).
- Force deaths to 1023, then collide → deaths stays 1023. Assert Reset mid-TRANSITION with timer=40 → immediate TITLE, timer=0, Level_Active=000.
